// File: rtl/irq_responder.sv
// irq_responder: answers every value change on i_req with one distinct o_resp word after an LFSR-chosen delay.
// Latency: 3 cycles from the request edge to o_resp at zero delay, plus the delay otherwise.
// No backpressure: a full request FIFO drops the event and sets sticky o_overflow. IRQ_RESPONDER_TRACE_EN adds $display tracing.

module fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   output logic             push_rdy,
   input  logic [WIDTH-1:0] push_dat,
   output logic             pop_vld,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] pop_dat
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push, do_pop;

   assign pop_vld  = (cnt != '0);
   assign do_pop   = pop_vld && pop_rdy;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push_rdy = (cnt != FULL_CNT) || do_pop;
   assign do_push  = push_vld && push_rdy;
   assign pop_dat  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module irq_responder #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned DELAY_MAX      = 15,
   parameter int unsigned TRANSACTION_NB = 1000,
   parameter logic [15:0] SEED           = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] resp_index,
   input  logic [31:0] i_req,
   output logic [31:0] o_resp,
   output logic        o_overflow,
   output logic [31:0] o_count,
   output logic        o_done
);
   typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_t;

   localparam int unsigned DLY_LIM = (DELAY_MAX > 15) ? 15 : DELAY_MAX;
   localparam logic [3:0]  DLY_CAP = DLY_LIM[3:0];
   localparam logic [31:0] TX_NB   = TRANSACTION_NB;

   state_t      state;
   logic [31:0] req_prev, req_q, head_dat, r0, r_next;
   logic [15:0] lfsr, lfsr_seed, lfsr_next, seed_mix;
   logic [3:0]  dly;
   logic        req_evt, fifo_rdy, fifo_vld, pop;
   logic        unused_idx;

   assign unused_idx = ^resp_index[31:16];
   assign req_evt    = (i_req != req_prev);
   assign pop        = (state == IDLE) && fifo_vld && !o_done;
   assign seed_mix   = SEED ^ resp_index[15:0];
   assign lfsr_seed  = (seed_mix == 16'h0000) ? 16'h0001 : seed_mix;
   assign lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
   assign r0         = {req_q[30:0], req_q[31]} ^ {resp_index[15:0], 16'h0000};
   // Flip bit 0 on a collision so the cpu always sees a change per response.
   assign r_next     = (r0 == o_resp) ? (r0 ^ 32'h1) : r0;

   fifo #(.WIDTH(32), .DEPTH(int'(FIFO_DEPTH))) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (req_evt),
      .push_rdy (fifo_rdy),
      .push_dat (i_req),
      .pop_vld  (fifo_vld),
      .pop_rdy  (pop),
      .pop_dat  (head_dat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         req_prev   <= '0;
         req_q      <= '0;
         dly        <= '0;
         lfsr       <= lfsr_seed;
         o_resp     <= '0;
         o_overflow <= 1'b0;
         o_count    <= '0;
         o_done     <= 1'b0;
      end else begin
         req_prev <= i_req;
         if (req_evt && !fifo_rdy) o_overflow <= 1'b1;
         case (state)
            IDLE: begin
               if (pop) begin
                  req_q <= head_dat;
                  dly   <= (lfsr[3:0] > DLY_CAP) ? DLY_CAP : lfsr[3:0];
                  lfsr  <= lfsr_next;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (dly == 4'd0) state <= EMIT;
               else             dly   <= dly - 4'd1;
            end
            EMIT: begin
               o_resp <= r_next;
               if (o_count != TX_NB)          o_count <= o_count + 32'd1;
               if (o_count + 32'd1 == TX_NB)  o_done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IRQ_RESPONDER_TRACE_EN
   always @(posedge clk) begin
      if (!rst) begin
         if (req_evt && fifo_rdy)  $display("[resp_%0d] req = 0x%08x", resp_index, i_req);
         if (req_evt && !fifo_rdy) $display("[resp_%0d] overflow", resp_index);
         if (state == EMIT)
            $display("[resp_%0d] resp = 0x%08x (%0d/%0d)", resp_index, r_next, o_count + 32'd1, TRANSACTION_NB);
      end
   end
`endif
endmodule

// File: tb/tb_irq_responder.sv
// Directed bench for irq_responder: four instances with different parameters, one per scenario group.
module tb_irq_responder;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [31:0] a_req, a_resp, a_count;
   logic        a_ovf, a_done;
   logic [31:0] c_req, c_resp, c_count;
   logic        c_ovf, c_done;
   logic [31:0] ov_req, ov_resp, ov_count;
   logic        ov_ovf, ov_done;
   logic [31:0] d_req, d_resp, d_count;
   logic        d_ovf, d_done;

   logic [31:0] c_log[$];
   logic [31:0] c_count_q;

   irq_responder u_a (
      .clk(clk), .rst(rst), .resp_index(32'd0), .i_req(a_req),
      .o_resp(a_resp), .o_overflow(a_ovf), .o_count(a_count), .o_done(a_done));

   irq_responder #(.FIFO_DEPTH(2), .DELAY_MAX(0)) u_c (
      .clk(clk), .rst(rst), .resp_index(32'd0), .i_req(c_req),
      .o_resp(c_resp), .o_overflow(c_ovf), .o_count(c_count), .o_done(c_done));

   irq_responder #(.FIFO_DEPTH(4), .DELAY_MAX(15)) u_o (
      .clk(clk), .rst(rst), .resp_index(32'd2), .i_req(ov_req),
      .o_resp(ov_resp), .o_overflow(ov_ovf), .o_count(ov_count), .o_done(ov_done));

   irq_responder #(.TRANSACTION_NB(3)) u_d (
      .clk(clk), .rst(rst), .resp_index(32'd0), .i_req(d_req),
      .o_resp(d_resp), .o_overflow(d_ovf), .o_count(d_count), .o_done(d_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every response word of u_c; responses are at least 3 cycles apart.
   initial c_count_q = '0;
   always @(negedge clk) begin
      if (c_count == c_count_q + 32'd1) c_log.push_back(c_resp);
      c_count_q = c_count;
   end

   task automatic do_reset();
      rst = 1'b1;
      a_req = '0; c_req = '0; ov_req = '0; d_req = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_req = '0; c_req = '0; ov_req = '0; d_req = '0;
      #1;
      checks++; if (a_resp !== 32'h0)  begin errors++; $display("FAIL reset_resp got %h want 0", a_resp); end
      checks++; if (a_count !== 32'h0) begin errors++; $display("FAIL reset_count got %h want 0", a_count); end
      checks++; if (a_ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
      checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", a_done); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Seed 0xACE1 gives a first delay of 1: response lands 4 edges after the push edge.
   task automatic test_single();
      @(negedge clk);
      a_req = 32'h8000_0001;
      repeat (4) @(negedge clk);
      checks++; if (a_resp !== 32'h0) begin errors++; $display("FAIL single_early got %h want 0", a_resp); end
      @(negedge clk);
      checks++; if (a_resp !== 32'h0000_0003) begin errors++; $display("FAIL single_resp got %h want 00000003", a_resp); end
      checks++; if (a_count !== 32'd1) begin errors++; $display("FAIL single_count got %0d want 1", a_count); end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      a_req = 32'h11;
      @(negedge clk);
      a_req = 32'h22;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (a_resp !== 32'h0)  begin errors++; $display("FAIL midwait_resp got %h want 0", a_resp); end
      checks++; if (a_count !== 32'h0) begin errors++; $display("FAIL midwait_count got %h want 0", a_count); end
      checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL midwait_done got %b want 0", a_done); end
      a_req = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (a_count !== 32'h0) begin errors++; $display("FAIL midwait_flushed_count got %h want 0", a_count); end
      checks++; if (a_resp !== 32'h0)  begin errors++; $display("FAIL midwait_flushed_resp got %h want 0", a_resp); end
      a_req = 32'h33;
      repeat (4) @(negedge clk);
      checks++; if (a_resp !== 32'h0) begin errors++; $display("FAIL reseed_early got %h want 0", a_resp); end
      @(negedge clk);
      checks++; if (a_resp !== 32'h66) begin errors++; $display("FAIL reseed_resp got %h want 00000066", a_resp); end
   endtask

   // Burst 0x10,0x20,1,0x40,1 into a depth-2 FIFO drops 0x40, so request 1 follows response 2 -> flip to 3.
   task automatic test_collision();
      logic [31:0] exp_log [7];
      logic [31:0] seq1 [3];
      logic [31:0] burst [5];
      exp_log = '{32'h2, 32'h1, 32'h2, 32'h20, 32'h40, 32'h2, 32'h3};
      seq1    = '{32'h1, 32'h8000_0000, 32'h1};
      burst   = '{32'h10, 32'h20, 32'h1, 32'h40, 32'h1};
      do_reset();
      c_log.delete();
      for (int i = 0; i < 3; i++) begin
         c_req = seq1[i];
         repeat (5) @(negedge clk);
      end
      for (int i = 0; i < 5; i++) begin
         c_req = burst[i];
         @(negedge clk);
      end
      repeat (20) @(negedge clk);
      checks++; if (c_log.size() != 7) begin errors++; $display("FAIL coll_nresp got %0d want 7", c_log.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (i >= c_log.size()) begin
            errors++; $display("FAIL coll_resp%0d got none want %h", i, exp_log[i]);
         end else if (c_log[i] !== exp_log[i]) begin
            errors++; $display("FAIL coll_resp%0d got %h want %h", i, c_log[i], exp_log[i]);
         end
      end
      checks++; if (c_ovf !== 1'b1) begin errors++; $display("FAIL coll_ovf got %b want 1", c_ovf); end
   endtask

   // Index 2 seeds 0xACE3: first delay 3, so the 6th consecutive request finds the FIFO full.
   task automatic test_overflow();
      do_reset();
      for (int v = 1; v <= 6; v++) begin
         ov_req = 32'(v);
         @(negedge clk);
      end
      for (int i = 0; i < 300 && ov_count < 32'd5; i++) @(negedge clk);
      repeat (60) @(negedge clk);
      checks++; if (ov_ovf !== 1'b1)   begin errors++; $display("FAIL ovf_flag got %b want 1", ov_ovf); end
      checks++; if (ov_count !== 32'd5) begin errors++; $display("FAIL ovf_count got %0d want 5", ov_count); end
      checks++; if (ov_resp !== 32'h0002_000A) begin errors++; $display("FAIL ovf_resp got %h want 0002000a", ov_resp); end
   endtask

   task automatic test_no_event();
      do_reset();
      a_req = 32'h1234_5678;
      repeat (50) @(negedge clk);
      checks++; if (a_count !== 32'd1) begin errors++; $display("FAIL noevt_count got %0d want 1", a_count); end
      checks++; if (a_resp !== 32'h2468_ACF0) begin errors++; $display("FAIL noevt_resp got %h want 2468acf0", a_resp); end
   endtask

   task automatic test_done();
      do_reset();
      for (int v = 1; v <= 5; v++) begin
         d_req = 32'(v) << 8;
         @(negedge clk);
      end
      for (int i = 0; i < 200 && !d_done; i++) @(negedge clk);
      checks++; if (d_done !== 1'b1)   begin errors++; $display("FAIL done_flag got %b want 1", d_done); end
      checks++; if (d_count !== 32'd3) begin errors++; $display("FAIL done_count got %0d want 3", d_count); end
      checks++; if (d_resp !== 32'h600) begin errors++; $display("FAIL done_resp got %h want 00000600", d_resp); end
      repeat (60) @(negedge clk);
      checks++; if (d_count !== 32'd3) begin errors++; $display("FAIL done_count_hold got %0d want 3", d_count); end
      checks++; if (d_resp !== 32'h600) begin errors++; $display("FAIL done_resp_frozen got %h want 00000600", d_resp); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_reset_mid_wait();
      test_collision();
      test_overflow();
      test_no_event();
      test_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
